// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and defaults for the fetch PC controller.
package fetch_pc_ctrl_pkg;

  // Default PC width and sequential increment.
  localparam int PKG_XLEN        = 32;
  localparam int PKG_INSTR_BYTES = 4;

  // Controller state; the encoding is exposed on state_o for debug.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HALTED = 3'd3
  } fetch_state_e;

  // One parked redirect, held while instruction memory is not ready.
  // The pc field is sized by the package default, so the controller's XLEN
  // must stay equal to PKG_XLEN.
  typedef struct packed {
    logic                valid;
    logic                is_trap;
    logic [PKG_XLEN-1:0] pc;
  } pend_entry_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect buffer. A trap always wins the slot; a flush
// may only replace an empty slot or another flush. Clear beats capture.
module pc_redirect_buf
  import fetch_pc_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                capture_i,
  input  logic                clear_i,
  input  logic                trap_i,
  input  logic [PKG_XLEN-1:0] trap_pc_i,
  input  logic                flush_i,
  input  logic [PKG_XLEN-1:0] flush_pc_i,
  output pend_entry_t         entry_o
);

  pend_entry_t r_entry;
  logic        w_trap_held;

  assign w_trap_held = r_entry.valid && r_entry.is_trap;

  // Capture or clear the pending redirect.
  // NOTE: the whole entry, pc included, is reset so no stale target survives
  // a reset; sequential state is always assigned with <=.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_entry <= '0;
    end else if (clear_i) begin
      r_entry <= '0;
    end else if (capture_i) begin
      if (trap_i) begin
        r_entry <= '{valid: 1'b1, is_trap: 1'b1, pc: trap_pc_i};
      end else if (flush_i && !w_trap_held) begin
        r_entry <= '{valid: 1'b1, is_trap: 1'b0, pc: flush_pc_i};
      end
    end
  end

  assign entry_o = r_entry;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: chooses the PC register's enable and next value with
// zero latency from the current state and inputs, parks redirects while
// instruction memory stalls, and counts applied redirects.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int XLEN        = PKG_XLEN,
  parameter int INSTR_BYTES = PKG_INSTR_BYTES,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [XLEN-1:0]  boot_pc_i,
  input  logic [XLEN-1:0]  cur_pc_i,
  input  logic             imem_ready_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  flush_pc_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic             halt_i,
  output logic             pc_en_o,
  output logic [XLEN-1:0]  next_pc_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [2:0]       state_o
);

  fetch_state_e     r_state;
  logic [CNT_W-1:0] r_redirect_cnt;

  fetch_state_e     w_next_state;
  logic             w_pc_en;
  logic [XLEN-1:0]  w_next_pc;
  logic             w_redirect;
  logic             w_capture;
  logic             w_clear;
  logic             w_pend_trap;
  pend_entry_t      w_pend;

  pc_redirect_buf u_redirect_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .capture_i  (w_capture),
    .clear_i    (w_clear),
    .trap_i     (trap_i),
    .trap_pc_i  (trap_pc_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .entry_o    (w_pend)
  );

  assign w_pend_trap = w_pend.valid && w_pend.is_trap;

  // Next-PC selection, buffer control and next state, by redirect priority.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_pc_en      = 1'b0;
    w_next_pc    = '0;
    w_redirect   = 1'b0;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    w_next_state = r_state;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_pc_en      = 1'b1;
          w_next_pc    = boot_pc_i;
          w_next_state = ST_RUN;
        end
      end

      ST_RUN, ST_WAIT: begin
        if (halt_i) begin
          w_clear      = 1'b1;
          w_next_state = ST_HALTED;
        end else if (!imem_ready_i) begin
          // Memory busy: park any redirect and hold the PC.
          w_capture    = 1'b1;
          w_next_state = ST_WAIT;
        end else begin
          // Memory ready: whatever is parked is consumed this cycle.
          w_clear      = 1'b1;
          w_next_state = ST_RUN;
          if (trap_i) begin
            w_pc_en    = 1'b1;
            w_redirect = 1'b1;
            w_next_pc  = trap_pc_i;
          end else if (flush_i && !w_pend_trap) begin
            w_pc_en    = 1'b1;
            w_redirect = 1'b1;
            w_next_pc  = flush_pc_i;
          end else if (w_pend.valid) begin
            w_pc_en    = 1'b1;
            w_redirect = 1'b1;
            w_next_pc  = w_pend.pc;
          end else if (!stall_i) begin
            // Carry out of the top bit is dropped: modulo 2^XLEN.
            w_pc_en    = 1'b1;
            w_next_pc  = cur_pc_i + XLEN'(INSTR_BYTES);
          end
        end
      end

      ST_HALTED: begin
        // Only a trap restarts fetch; flushes are ignored here.
        if (trap_i) begin
          w_pc_en      = 1'b1;
          w_redirect   = 1'b1;
          w_next_pc    = trap_pc_i;
          w_next_state = ST_RUN;
        end
      end

      default: w_next_state = ST_IDLE;
    endcase

    // While reset is asserted nothing may load the PC.
    if (!rst_ni) begin
      w_pc_en    = 1'b0;
      w_next_pc  = '0;
      w_redirect = 1'b0;
    end
  end

  // State register and redirect counter (wraps naturally at 2^CNT_W).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_redirect) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_en_o        = w_pc_en;
  assign next_pc_o      = w_next_pc;
  assign redirect_cnt_o = r_redirect_cnt;
  assign state_o        = r_state;

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter INSTR_BYTES, default 4, sequential PC increment.
REQ-003 Parameter CNT_W, default 16, redirect counter width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  leave IDLE and begin fetch at boot_pc_i.
REQ-007 boot_pc_i  input  XLEN  first fetch address.
REQ-008 cur_pc_i  input  XLEN  current value of the PC register.
REQ-009 imem_ready_i  input  1  instruction memory accepts a new fetch this cycle.
REQ-010 stall_i  input  1  decode backpressure; hold PC.
REQ-011 flush_i / flush_pc_i  input  1 / XLEN  branch/jump redirect and target.
REQ-012 trap_i / trap_pc_i  input  1 / XLEN  exception redirect and handler address.
REQ-013 halt_i  input  1  stop fetching.
REQ-014 pc_en_o  output  1  load enable for the PC register.
REQ-015 next_pc_o  output  XLEN  value the PC register loads when pc_en_o=1.
REQ-016 redirect_cnt_o  output  CNT_W  count of applied redirects.
REQ-017 state_o  output  3  encoded FSM state, debug only.

Function
REQ-018 FSM states SHALL be IDLE, RUN, WAIT, HALTED; pc_en_o and next_pc_o SHALL be combinational from state and inputs (zero latency).
REQ-019 IDLE: pc_en_o=0; on start_i=1 drive pc_en_o=1, next_pc_o=boot_pc_i, go to RUN.
REQ-020 Priority in RUN and WAIT SHALL be halt_i > trap_i > flush_i > pending redirect > sequential.
REQ-021 RUN, imem_ready_i=1: trap_i -> next_pc_o=trap_pc_i, pc_en_o=1; else flush_i -> flush_pc_i, pc_en_o=1; else stall_i=0 -> cur_pc_i+INSTR_BYTES, pc_en_o=1; else pc_en_o=0.
REQ-022 Redirects with imem_ready_i=1 SHALL apply even when stall_i=1.
REQ-023 RUN, imem_ready_i=0: pc_en_o=0, go to WAIT; any trap_i/flush_i that cycle is latched in the pending buffer.
REQ-024 Pending buffer holds one redirect (valid, is_trap, pc); a new trap overwrites any pending entry; a new flush overwrites only a pending flush, never a pending trap.
REQ-025 WAIT, imem_ready_i=0: pc_en_o=0, keep capturing redirects per REQ-024.
REQ-026 WAIT, imem_ready_i=1: apply a same-cycle new redirect per REQ-020, except a new flush SHALL NOT override a pending trap; else apply pending entry; else sequential if stall_i=0; clear pending when applied; return to RUN.
REQ-027 Sequential add SHALL be modulo 2^XLEN (0xFFFFFFFC+4 -> 0x00000000).
REQ-028 halt_i in RUN/WAIT: pc_en_o=0, clear pending, go to HALTED.
REQ-029 HALTED: pc_en_o=0; exits only on trap_i, driving pc_en_o=1, next_pc_o=trap_pc_i, go to RUN; flush_i ignored.
REQ-030 redirect_cnt_o SHALL increment by one each cycle pc_en_o=1 with a trap or flush target (new or pending), wrapping at 2^CNT_W.
REQ-031 start_i SHALL be ignored outside IDLE.

Reset
REQ-032 On rst_ni=0 state SHALL be IDLE, pending valid=0, pending pc=0, redirect_cnt_o=0, immediately and independent of clk_i.
REQ-033 In reset pc_en_o=0 and next_pc_o=0.
REQ-034 Reset mid-WAIT SHALL discard any pending redirect; first fetch after reset requires start_i.

Structure
REQ-035 Package fetch_pc_ctrl_pkg SHALL hold the FSM state enum, default XLEN, INSTR_BYTES and the pending-entry struct.
REQ-036 The pending buffer SHALL be a sub-module pc_redirect_buf (capture, overwrite priority, clear).
REQ-037 Block SHALL drive the PC register's enable and next-value inputs directly; no extra pipeline register.

Verification
REQ-038 Reset release, start_i=1, boot_pc_i=0x80000000 -> same cycle pc_en_o=1, next_pc_o=0x80000000; following cycles +4 with imem_ready_i=1.
REQ-039 cur_pc_i=0x100, stall_i=1, flush_i=1, flush_pc_i=0x400 -> pc_en_o=1, next_pc_o=0x400, redirect_cnt_o 0->1.
REQ-040 imem_ready_i=0 for 3 cycles, flush 0x200 in cycle 1, trap 0x800 in cycle 2, flush 0x300 in cycle 3 -> pc_en_o=0 throughout; on ready next_pc_o=0x800, cnt +1.
REQ-041 halt_i=1 in RUN -> pc_en_o=0; flush_i ignored; trap_i with trap_pc_i=0x20 -> pc_en_o=1, next_pc_o=0x20, state RUN.
REQ-042 cur_pc_i=0xFFFFFFFC sequential -> next_pc_o=0x00000000; rst_ni low during WAIT with pending flush -> IDLE, cnt=0, no redirect after restart.
